// File: rtl/led_seq_player.sv
// led_seq_player: steps through LED frames of the selected sequence, one frame per step tick, via a synchronous ROM.
// Build macro LED_SEQ_PLAYER_PINGPONG_EN selects ping-pong frame order instead of forward-only.
module led_seq_player #(
    parameter int SEQ_BITS   = 3,
    parameter int FRAME_BITS = 3,
    parameter int LED_W      = 8
) (
    input  logic                           clk_50,
    input  logic                           reset,
    input  logic                           step_tick,
    input  logic [SEQ_BITS-1:0]            seq_num,
    input  logic [LED_W-1:0]               rom_data,
    output logic                           rom_rd,
    output logic [SEQ_BITS+FRAME_BITS-1:0] rom_addr,
    output logic [LED_W-1:0]               LEDS,
    output logic [FRAME_BITS-1:0]          frame_idx,
    output logic                           wrap
);
    typedef enum logic [1:0] {WAIT, READ, LOAD} state_t;
    localparam logic [FRAME_BITS-1:0] LAST = '1;
    state_t state, state_next;
    logic [SEQ_BITS-1:0] seq_latched;
    logic [FRAME_BITS-1:0] frame_fetch, frame_next;
    logic seq_change, accept, pass_done;
    assign seq_change  = seq_num != seq_latched;
    assign accept      = state == WAIT && step_tick;
    assign frame_fetch = seq_change ? '0 : frame_idx;
    always_comb begin
        state_next = state;
        state_next = state == WAIT ? (step_tick ? READ : WAIT) : state == READ ? LOAD : WAIT;
        rom_rd     = state == READ;
    end
`ifdef LED_SEQ_PLAYER_PINGPONG_EN
    logic dir, dir_next;
    // dir=1 means travelling backward; reverse at either end so no frame repeats
    assign dir_next   = dir ? frame_idx != '0 : frame_idx == LAST;
    assign frame_next = dir_next ? frame_idx - 1'b1 : frame_idx + 1'b1;
    assign pass_done  = dir && frame_idx == '0;
    always_ff @(posedge clk_50) begin
        if (reset)
            dir <= 1'b0;
        else if (accept && seq_change)
            dir <= 1'b0;
        else if (state == LOAD)
            dir <= dir_next;
    end
`else
    assign frame_next = frame_idx + 1'b1;
    assign pass_done  = frame_idx == LAST;
`endif
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state       <= WAIT;
            LEDS        <= '0;
            rom_addr    <= '0;
            frame_idx   <= '0;
            wrap        <= 1'b0;
            seq_latched <= '0;
        end else begin
            state <= state_next;
            wrap  <= state == LOAD && pass_done;
            if (accept) begin
                seq_latched <= seq_num;
                frame_idx   <= frame_fetch;
                rom_addr    <= {seq_num, frame_fetch};
            end
            if (state == LOAD) begin
                LEDS      <= rom_data;
                frame_idx <= frame_next;
            end
        end
    end
endmodule
